regfile_port_arbiter: RTL

//   Round-robin arbiter that shares the single 8x8 RegisterFile port set
//   (one write port wa3/wd3/we3, two read ports ra1/ra2 -> rd1/rd2) among
//   N_REQ requesters, for example a control FSM, a UART loader and the

---
 rtl/regfile_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one register-file port set among N_REQ requesters.
// Supports locked multi-cycle ownership and returns registered read data.
module regfile_port_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_lock,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_wa,
    input  logic [N_REQ*DATA_W-1:0]  req_wd,
    input  logic [N_REQ*ADDR_W-1:0]  req_ra1,
    input  logic [N_REQ*ADDR_W-1:0]  req_ra2,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_rd1,
    output logic [DATA_W-1:0]        rsp_rd2,
    output logic                     rf_we3,
    output logic [ADDR_W-1:0]        rf_wa3,
    output logic [DATA_W-1:0]        rf_wd3,
    output logic [ADDR_W-1:0]        rf_ra1,
    output logic [ADDR_W-1:0]        rf_ra2,
    input  logic [DATA_W-1:0]        rf_rd1,
    input  logic [DATA_W-1:0]        rf_rd2
);

    localparam int PW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [N_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0] rd1_q, rd2_q;

    logic [N_REQ-1:0]  act;
    logic              fire;
    logic              lock_hit;
    logic              found;

    assign act      = gnt_q & req;
    assign fire     = |act;
    assign lock_hit = |(act & req_lock);

    // gnt_q is one-hot, so at most one term of this OR-mux is active
    always_comb begin
        rf_we3 = 1'b0;
        rf_wa3 = '0;
        rf_wd3 = '0;
        rf_ra1 = '0;
        rf_ra2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (act[i]) begin
                rf_we3 = req_we[i];
                rf_wa3 = req_wa[i*ADDR_W +: ADDR_W];
                rf_wd3 = req_wd[i*DATA_W +: DATA_W];
                rf_ra1 = req_ra1[i*ADDR_W +: ADDR_W];
                rf_ra2 = req_ra2[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        gnt_d  = '0;
        rr_d   = rr_q;
        hold_d = '0;
        found  = 1'b0;
        if (lock_hit && (hold_q < HOLD_LIM)) begin
            gnt_d  = gnt_q;
            hold_d = hold_q + HW'(1);
        end else begin
            // k-th slot after rr_q is requester j when rr_q == (j-k) mod N
            for (int k = 0; k < N_REQ; k++) begin
                for (int j = 0; j < N_REQ; j++) begin
                    if (!found && req[j] &&
                        rr_q == PW'((j - k + N_REQ) % N_REQ)) begin
                        found    = 1'b1;
                        gnt_d    = '0;
                        gnt_d[j] = 1'b1;
                        rr_d     = PW'((j + 1) % N_REQ);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q       <= '0;
            rr_q        <= '0;
            hold_q      <= '0;
            rsp_valid_q <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
        end else begin
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            hold_q      <= hold_d;
            rsp_valid_q <= act;
            if (fire) begin
                rd1_q <= rf_rd1;
                rd2_q <= rf_rd2;
            end
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rd1   = rd1_q;
    assign rsp_rd2   = rd2_q;

endmodule
